// File: rtl/fifo_pkg.sv
// Shared definitions for FIFO read/write side adapters: buffer occupancy
// type, buffer depth and the read-issue condition.
package fifo_pkg;

    // Occupancy of a 2-entry buffer (values 0..2).
    typedef logic [1:0] occ_t;

    localparam int unsigned BUF_DEPTH = 2;

    // A read may be issued when the FIFO has data and the words already
    // buffered plus those still in flight, minus the word leaving this cycle,
    // leave room for one more.
    function automatic logic rd_issue_ok(
        input logic empty,
        input occ_t occ,
        input logic pend,
        input logic pop
    );
        logic [2:0] commit;
        commit = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
        return (!empty) && (commit < 3'(BUF_DEPTH));
    endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry in-order data queue. Entry 0 is always the head; a pop shifts
// entry 1 forward, a push lands in the first free slot (or behind the
// advancing head when push and pop coincide).
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    occ_t                  occ_q,  occ_d;

    // Next-state of the entries and occupancy for every push/pop combination.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    ent0_d = push_data;
                    occ_d  = 2'd1;
                end else if (occ_q == 2'd1) begin
                    ent1_d = push_data;
                    occ_d  = 2'd2;
                end else begin
                    // Full: the caller never pushes here; keep contents intact.
                    occ_d  = occ_q;
                end
            end
            2'b01: begin
                if (occ_q != 2'd0) begin
                    ent0_d = ent1_q;
                    occ_d  = occ_q - 2'd1;
                end else begin
                    occ_d  = occ_q;
                end
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end else begin
                    ent0_d = push_data;
                end
                occ_d = (occ_q == 2'd0) ? 2'd1 : occ_q;
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Entry and occupancy registers; reset discards all buffered words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data = ent0_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for syncfifo: drains the FIFO through rd_en/empty/dout
// and presents the words as a valid/ready stream at one word per cycle.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          FWFT_EN    = 1'b0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    logic                 pend_q, pend_d;
    logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
    logic                 pop_s;
    logic                 push_s;
    logic                 rd_en_s;
    occ_t                 occ_s;

    assign pop_s   = m_valid & m_ready;
    assign rd_en_s = rd_issue_ok(fifo_empty, occ_s, pend_q, pop_s);

    // Read-in-flight tracking and capture timing; in FWFT mode dout is
    // already valid when rd_en is raised, so nothing is ever in flight.
    always_comb begin
        if (FWFT_EN == 1'b1) begin
            pend_d = 1'b0;
            push_s = rd_en_s;
        end else begin
            pend_d = rd_en_s;
            push_s = pend_q;
        end
    end

    // Handshake counter, wrapping naturally at 2**CNT_WIDTH.
    always_comb begin
        if (pop_s) begin
            xfer_cnt_d = xfer_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end
    end

    // In-flight flag and transfer counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    stream_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (fifo_dout),
        .pop       (pop_s),
        .head_data (m_data),
        .occ       (occ_s)
    );

    // m_valid comes straight from the occupancy register, never from m_ready.
    assign m_valid    = (occ_s != 2'd0);
    assign fifo_rd_en = rd_en_s;
    assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a standard-mode instance (a) and an FWFT
// instance (b), each fed by a small behavioural syncfifo. Expected words go
// into per-instance queues when written and are compared on every handshake.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          total = 0;
    int          bad = 0;

    // instance a: FWFT_EN=0
    logic [7:0]  dout_a, mdata_a, wd_a;
    logic        empty_a, rd_a, mvalid_a, wr_a, gate_a;
    logic        mready_a;
    logic [15:0] xcnt_a;
    logic [7:0]  mem_a [0:31];
    logic [5:0]  wp_a, rp_a;
    logic [7:0]  exp_a [$];

    // instance b: FWFT_EN=1
    logic [7:0]  dout_b, mdata_b, wd_b;
    logic        empty_b, rd_b, mvalid_b, wr_b, gate_b;
    logic        mready_b;
    logic [15:0] xcnt_b;
    logic [7:0]  mem_b [0:31];
    logic [5:0]  wp_b, rp_b;
    logic [7:0]  exp_b [$];

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(8), .FWFT_EN(1'b0), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .fifo_dout(dout_a), .fifo_empty(empty_a),
        .fifo_rd_en(rd_a), .m_data(mdata_a), .m_valid(mvalid_a),
        .m_ready(mready_a), .xfer_cnt(xcnt_a));

    fifo_stream_reader #(.DATA_WIDTH(8), .FWFT_EN(1'b1), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .fifo_dout(dout_b), .fifo_empty(empty_b),
        .fifo_rd_en(rd_b), .m_data(mdata_b), .m_valid(mvalid_b),
        .m_ready(mready_b), .xfer_cnt(xcnt_b));

    // syncfifo models; gate_x hides the contents from the reader while preloading
    assign empty_a = gate_a | (wp_a == rp_a);
    assign empty_b = gate_b | (wp_b == rp_b);
    assign dout_b  = mem_b[rp_b[4:0]];

    always_ff @(posedge clk) begin
        if (wr_a) mem_a[wp_a[4:0]] <= wd_a;
        if (wr_b) mem_b[wp_b[4:0]] <= wd_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_a <= 6'd0; rp_a <= 6'd0; dout_a <= 8'd0;
            wp_b <= 6'd0; rp_b <= 6'd0;
        end else begin
            if (wr_a) wp_a <= wp_a + 6'd1;
            if (rd_a) begin dout_a <= mem_a[rp_a[4:0]]; rp_a <= rp_a + 6'd1; end
            if (wr_b) wp_b <= wp_b + 6'd1;
            if (rd_b) rp_b <= rp_b + 6'd1;
        end
    end

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0; gate_a = 1'b1; gate_b = 1'b1;
        wr_a = 1'b0; wr_b = 1'b0; wd_a = 8'd0; wd_b = 8'd0;
        mready_a = 1'b0; mready_b = 1'b0;
        exp_a.delete(); exp_b.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // write n words first, first+1, ... into FIFO sel (0=a, 1=b)
    task automatic preload(input bit sel, input int n, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sel) begin wr_b = 1'b1; wd_b = first + 8'(i); exp_b.push_back(wd_b); end
            else     begin wr_a = 1'b1; wd_a = first + 8'(i); exp_a.push_back(wd_a); end
        end
        @(negedge clk);
        wr_a = 1'b0; wr_b = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0; gate_a = 1'b0; gate_b = 1'b0; mready_a = 1'b1; mready_b = 1'b1;
        wr_a = 1'b0; wr_b = 1'b0;
        #1;
        total++; if (mvalid_a !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", mvalid_a); end
        total++; if (mdata_a !== 8'd0) begin bad++; $display("FAIL reset_data got=%h exp=00", mdata_a); end
        total++; if (xcnt_a !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", xcnt_a); end
        total++; if (rd_a !== 1'b0 || rd_b !== 1'b0) begin bad++; $display("FAIL reset_rd got=%b%b exp=00", rd_a, rd_b); end
        total++; if (mvalid_b !== 1'b0) begin bad++; $display("FAIL reset_valid_b got=%b exp=0", mvalid_b); end
    endtask

    task automatic test_stream_full;
        int first_v, rd_n, rd_first, rd_last, pops, p_first, p_last, uf;
        logic [7:0] e;
        do_reset();
        preload(1'b0, 16, 8'd1);
        mready_a = 1'b1; first_v = -1; rd_n = 0; rd_first = -1; rd_last = -1;
        pops = 0; p_first = -1; p_last = -1; uf = 0;
        gate_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (rd_a && empty_a) uf++;
            if (rd_a) begin rd_n++; if (rd_first < 0) rd_first = i; rd_last = i; end
            if (mvalid_a && first_v < 0) first_v = i;
            if (mvalid_a && mready_a) begin
                pops++; if (p_first < 0) p_first = i; p_last = i;
                e = (exp_a.size() > 0) ? exp_a.pop_front() : 8'hxx;
                total++; if (mdata_a !== e) begin bad++; $display("FAIL full_data got=%h exp=%h", mdata_a, e); end
            end
            @(negedge clk);
        end
        #1;
        total++; if (first_v != 2) begin bad++; $display("FAIL full_latency got=%0d exp=2", first_v); end
        total++; if (pops != 16 || p_last - p_first != 15) begin bad++; $display("FAIL full_pops got=%0d span=%0d exp=16 span=15", pops, p_last - p_first); end
        total++; if (rd_n != 16 || rd_last - rd_first != 15) begin bad++; $display("FAIL full_rd got=%0d span=%0d exp=16 span=15", rd_n, rd_last - rd_first); end
        total++; if (xcnt_a !== 16'd16) begin bad++; $display("FAIL full_cnt got=%0d exp=16", xcnt_a); end
        total++; if (empty_a !== 1'b1 || uf != 0) begin bad++; $display("FAIL full_empty got=%b underflows=%0d exp=1 0", empty_a, uf); end
    endtask

    task automatic test_backpressure;
        int rd_n, pops;
        logic [7:0] e;
        do_reset();
        preload(1'b0, 16, 8'd1);
        mready_a = 1'b0; rd_n = 0; pops = 0;
        gate_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rd_a) rd_n++;
            if (i >= 2) begin
                total++;
                if (mvalid_a !== 1'b1 || mdata_a !== 8'd1) begin
                    bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/01", i, mvalid_a, mdata_a);
                end
            end
            @(negedge clk);
        end
        total++; if (rd_n != 2) begin bad++; $display("FAIL bp_reads got=%0d exp=2", rd_n); end
        total++; if (wp_a - rp_a != 6'd14) begin bad++; $display("FAIL bp_left got=%0d exp=14", wp_a - rp_a); end
        mready_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (mvalid_a && mready_a) begin
                pops++;
                e = (exp_a.size() > 0) ? exp_a.pop_front() : 8'hxx;
                total++; if (mdata_a !== e) begin bad++; $display("FAIL bp_data got=%h exp=%h", mdata_a, e); end
            end
            @(negedge clk);
        end
        total++; if (pops != 16) begin bad++; $display("FAIL bp_pops got=%0d exp=16", pops); end
    endtask

    task automatic test_toggle;
        int pops, uf;
        logic [7:0] e;
        do_reset();
        preload(1'b0, 16, 8'd1);
        pops = 0; uf = 0;
        gate_a = 1'b0;
        for (int i = 0; i < 60; i++) begin
            mready_a = (i % 2 == 0);
            #1;
            if (rd_a && empty_a) uf++;
            if (mvalid_a && mready_a) begin
                pops++;
                e = (exp_a.size() > 0) ? exp_a.pop_front() : 8'hxx;
                total++; if (mdata_a !== e) begin bad++; $display("FAIL tog_data got=%h exp=%h", mdata_a, e); end
            end
            @(negedge clk);
        end
        #1;
        total++; if (pops != 16 || exp_a.size() != 0) begin bad++; $display("FAIL tog_pops got=%0d left=%0d exp=16 0", pops, exp_a.size()); end
        total++; if (xcnt_a !== 16'd16) begin bad++; $display("FAIL tog_cnt got=%0d exp=16", xcnt_a); end
        total++; if (uf != 0) begin bad++; $display("FAIL tog_underflow got=%0d exp=0", uf); end
    endtask

    task automatic test_single_words;
        int vn, v1, v2;
        logic [7:0] e;
        do_reset();
        gate_a = 1'b0; mready_a = 1'b1; vn = 0; v1 = -1; v2 = -1;
        for (int i = 0; i < 25; i++) begin
            wr_a = 1'b0;
            if (i == 0)  begin wr_a = 1'b1; wd_a = 8'hA5; exp_a.push_back(8'hA5); end
            if (i == 11) begin wr_a = 1'b1; wd_a = 8'h3C; exp_a.push_back(8'h3C); end
            #1;
            if (mvalid_a) begin
                vn++; if (v1 < 0) v1 = i; else v2 = i;
                e = (exp_a.size() > 0) ? exp_a.pop_front() : 8'hxx;
                total++; if (mdata_a !== e) begin bad++; $display("FAIL single_data got=%h exp=%h", mdata_a, e); end
            end
            @(negedge clk);
        end
        wr_a = 1'b0;
        total++; if (vn != 2 || v2 - v1 <= 1) begin bad++; $display("FAIL single_beats got=%0d gap=%0d exp=2 isolated", vn, v2 - v1); end
    endtask

    task automatic test_fwft;
        int first_v, pops, p_first, p_last;
        logic [7:0] e;
        do_reset();
        preload(1'b1, 5, 8'd1);
        mready_b = 1'b1; first_v = -1; pops = 0; p_first = -1; p_last = -1;
        gate_b = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (mvalid_b && first_v < 0) first_v = i;
            if (mvalid_b && mready_b) begin
                pops++; if (p_first < 0) p_first = i; p_last = i;
                e = (exp_b.size() > 0) ? exp_b.pop_front() : 8'hxx;
                total++; if (mdata_b !== e) begin bad++; $display("FAIL fwft_data got=%h exp=%h", mdata_b, e); end
            end
            @(negedge clk);
        end
        #1;
        total++; if (first_v != 1) begin bad++; $display("FAIL fwft_latency got=%0d exp=1", first_v); end
        total++; if (pops != 5 || p_last - p_first != 4) begin bad++; $display("FAIL fwft_pops got=%0d span=%0d exp=5 span=4", pops, p_last - p_first); end
        total++; if (xcnt_b !== 16'd5) begin bad++; $display("FAIL fwft_cnt got=%0d exp=5", xcnt_b); end
    endtask

    task automatic test_async_reset;
        int pops;
        logic [7:0] e;
        do_reset();
        preload(1'b0, 16, 8'd1);
        mready_a = 1'b1; pops = 0;
        gate_a = 1'b0;
        for (int i = 0; i < 30 && pops < 7; i++) begin
            #1;
            if (mvalid_a && mready_a) begin
                pops++;
                e = (exp_a.size() > 0) ? exp_a.pop_front() : 8'hxx;
                total++; if (mdata_a !== e) begin bad++; $display("FAIL ar_data got=%h exp=%h", mdata_a, e); end
            end
            @(negedge clk);
        end
        #1;
        total++; if (xcnt_a !== 16'd7 || mvalid_a !== 1'b1) begin bad++; $display("FAIL ar_pre got=%0d/%b exp=7/1", xcnt_a, mvalid_a); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (mvalid_a !== 1'b0 || mdata_a !== 8'd0 || xcnt_a !== 16'd0) begin
            bad++; $display("FAIL ar_async got=%b/%h/%0d exp=0/00/0", mvalid_a, mdata_a, xcnt_a);
        end
        @(negedge clk);
        rst_n = 1'b1; gate_a = 1'b1; exp_a.delete(); pops = 0;
        preload(1'b0, 3, 8'd1);
        gate_a = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if (mvalid_a && mready_a) begin
                pops++;
                e = (exp_a.size() > 0) ? exp_a.pop_front() : 8'hxx;
                total++; if (mdata_a !== e) begin bad++; $display("FAIL ar_post_data got=%h exp=%h", mdata_a, e); end
            end
            @(negedge clk);
        end
        #1;
        total++; if (pops != 3 || xcnt_a !== 16'd3) begin bad++; $display("FAIL ar_post got=%0d/%0d exp=3/3", pops, xcnt_a); end
    endtask

    initial begin
        gate_a = 1'b1; gate_b = 1'b1; wr_a = 1'b0; wr_b = 1'b0;
        wd_a = 8'd0; wd_b = 8'd0; mready_a = 1'b0; mready_b = 1'b0;
        test_reset();
        test_stream_full();
        test_backpressure();
        test_toggle();
        test_single_words();
        test_fwft();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
